inst_encoder: RTL

- Instruction encoder for the pipeline's program-load and self-test paths: the inverse of immediate extraction in decode.
- Accepts decoded fields (format, opcode, register indices, funct3/funct7, 32-bit signed immediate) over a valid/ready handshake.
- Packs the fields into an RV32I instruction word and presents it on a registered valid/ready output together with its target word address.
- Optionally flags immediates that cannot be represented in the selected format.

---
 rtl/inst_encoder_if.sv | 37 +++
 rtl/inst_encoder.sv | 120 ++++++++++++
 2 files changed

// File: rtl/inst_encoder_if.sv
// rtl/inst_encoder_if.sv - Request, response and control bundle for inst_encoder
interface inst_encoder_if #(
  parameter int ADDR_W   = 32,
  parameter int ERRCNT_W = 8
);
  // Request side
  logic                in_valid;
  logic                in_ready;
  logic [2:0]          fmt;
  logic [6:0]          opcode;
  logic [4:0]          rd;
  logic [4:0]          rs1;
  logic [4:0]          rs2;
  logic [2:0]          funct3;
  logic [6:0]          funct7;
  logic [31:0]         imm;
  logic                flush;
  // Response side
  logic                out_valid;
  logic                out_ready;
  logic [31:0]         inst;
  logic [ADDR_W-1:0]   addr;
  logic                err;
  logic [ERRCNT_W-1:0] err_count;

  // Producer of requests / consumer of encoded words
  modport master (
    output in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm, flush, out_ready,
    input  in_ready, out_valid, inst, addr, err, err_count
  );

  // Encoder side
  modport slave (
    input  in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm, flush, out_ready,
    output in_ready, out_valid, inst, addr, err, err_count
  );
endinterface

// File: rtl/inst_encoder.sv
// rtl/inst_encoder.sv - RV32I field packer with one output register stage; IMM_CHECK_EN enables immediate range checks
module inst_encoder #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter int                ERRCNT_W  = 8
) (
  input logic           clk,
  input logic           rst,
  inst_encoder_if.slave bus
);

  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  logic                out_valid_q, out_valid_d;
  logic [31:0]         inst_q, inst_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                err_q, err_d;
  logic [ERRCNT_W-1:0] err_count_q, err_count_d;

  logic        accept;
  logic        out_hs;
  logic [31:0] enc_word;
  logic        fmt_illegal;
  logic        imm_bad;
  logic        enc_err;

  // Pack the request fields into the selected format; unknown formats become a NOP
  always_comb begin
    enc_word    = NOP_WORD;
    fmt_illegal = 1'b0;
    case (bus.fmt)
      3'd0: enc_word = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode};
      3'd1: enc_word = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
      3'd2: enc_word = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3, bus.imm[4:0], bus.opcode};
      3'd3: enc_word = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                        bus.imm[4:1], bus.imm[11], bus.opcode};
      3'd4: enc_word = {bus.imm[31:12], bus.rd, bus.opcode};
      3'd5: enc_word = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12],
                        bus.rd, bus.opcode};
      default: fmt_illegal = 1'b1;
    endcase
  end

`ifdef IMM_CHECK_EN
  logic signed [31:0] imm_s;

  // Flag immediates that the selected format would silently truncate or misalign
  always_comb begin
    imm_s   = $signed(bus.imm);
    imm_bad = 1'b0;
    case (bus.fmt)
      3'd1, 3'd2: imm_bad = (imm_s < -32'sd2048) || (imm_s > 32'sd2047);
      3'd3:       imm_bad = (imm_s < -32'sd4096) || (imm_s > 32'sd4094) || bus.imm[0];
      3'd4:       imm_bad = (bus.imm[11:0] != 12'd0);
      3'd5:       imm_bad = (imm_s < -32'sd1048576) || (imm_s > 32'sd1048574) || bus.imm[0];
      default:    imm_bad = 1'b0;
    endcase
  end
`else
  assign imm_bad = 1'b0;
`endif

  assign enc_err = fmt_illegal || imm_bad;

  // A flush cancels both the accept and the output handshake of its cycle
  assign bus.in_ready = !out_valid_q || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready && !bus.flush;
  assign out_hs       = out_valid_q && bus.out_ready && !bus.flush;

  // Next state of the output stage, address counter and error counter
  always_comb begin
    out_valid_d = out_valid_q;
    inst_d      = inst_q;
    addr_d      = addr_q;
    err_d       = err_q;
    err_count_d = err_count_q;
    if (bus.flush) begin
      out_valid_d = 1'b0;
      addr_d      = BASE_ADDR;
    end else begin
      if (out_hs) begin
        out_valid_d = 1'b0;
        addr_d      = addr_q + ADDR_W'(4);
        if (err_q && (err_count_q != '1)) begin
          err_count_d = err_count_q + ERRCNT_W'(1);
        end
      end
      // Loading after the handshake lets a word retire and its successor land in one cycle
      if (accept) begin
        out_valid_d = 1'b1;
        inst_d      = enc_word;
        err_d       = enc_err;
      end
    end
  end

  // Output register stage; reset drops any held word at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      inst_q      <= '0;
      addr_q      <= BASE_ADDR;
      err_q       <= 1'b0;
      err_count_q <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      inst_q      <= inst_d;
      addr_q      <= addr_d;
      err_q       <= err_d;
      err_count_q <= err_count_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.inst      = inst_q;
  assign bus.addr      = addr_q;
  assign bus.err       = err_q;
  assign bus.err_count = err_count_q;

endmodule
